vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: VGA_Timing_Ctrl

Interface
REQ-001 Parameter PULSE_WIDTH, default 8: width of the sync and front-porch fields.
REQ-002 Parameter REZ_MAX_WIDTH, default 12: width of the total/active fields and pixel coordinates.
REQ-003 Clk  in  1  system/pixel clock; all state changes on rising edge.
REQ-004 Rst  in  1  synchronous, active-high reset.
REQ-005 Enable  in  1  run request; sampled every cycle.
REQ-006 Cfg_valid  in  1  configuration offer.
REQ-007 Cfg_ready  out  1  high when a configuration can be accepted.
REQ-008 Cfg_h_total, Cfg_h_active, Cfg_v_total, Cfg_v_active  in  REZ_MAX_WIDTH each  line/frame totals and visible counts.
REQ-009 Cfg_h_front, Cfg_h_sync, Cfg_v_front, Cfg_v_sync  in  PULSE_WIDTH each  front porch and sync widths.
REQ-010 Cfg_err  out  1  one-cycle pulse: offered configuration rejected.
REQ-011 Hsync, Vsync  out  1 each  active-low sync.
REQ-012 Display_en  out  1  high inside the visible area.
REQ-013 PixelX, PixelY  out  REZ_MAX_WIDTH each  current position.
REQ-014 Frame_start  out  1  one-cycle pulse at position (0,0).
REQ-015 Running  out  1  high in state RUN.

Function
REQ-016 Handshake: a transfer occurs when Cfg_valid and Cfg_ready are both high on a rising edge.
REQ-017 Validity check on each transfer: active != 0, active+front+sync <= total, and total >= 2, for both H and V, with the sums computed at REZ_MAX_WIDTH+1 bits. A failing transfer is dropped, Cfg_err pulses on the next cycle, and state is unchanged.
REQ-018 Registers: the active set drives timing. A one-entry shadow set has a flag Pend.
REQ-019 Cfg_ready = not Pend.
REQ-020 A valid transfer in IDLE writes the active set directly and sets Have_cfg. A valid transfer in RUN writes the shadow set and sets Pend.
REQ-021 States:
- IDLE: counters held at 0, Hsync=1, Vsync=1, Display_en=0.
- RUN: counting.
REQ-022 IDLE->RUN when Have_cfg=1 and Enable=1. The first RUN cycle shows PixelX=0, PixelY=0, Frame_start=1.
REQ-023 Horizontal counter in RUN: increments by 1 each cycle and wraps to 0 after h_total-1. The vertical counter increments on each H wrap and wraps to 0 after v_total-1.
REQ-024 Frame end: the cycle with PixelX=h_total-1 and PixelY=v_total-1.
REQ-025 At frame end with Pend=1: the shadow is copied to the active set and Pend clears. The new timing takes effect from the next (0,0).
REQ-026 At frame end with Enable=0: RUN->IDLE. If Pend=1, the shadow copy still occurs.
REQ-027 Enable=0 mid-frame has no effect until frame end; the frame is always completed.
REQ-028 Decode, all outputs registered and coherent with PixelX/PixelY of the same cycle:
- Display_en = (X < h_active) and (Y < v_active).
- Hsync=0 for X in [h_active+h_front, h_active+h_front+h_sync).
- Vsync=0 for Y in [v_active+v_front, v_active+v_front+v_sync).
REQ-029 Zero-width cases:
- h_sync=0 or v_sync=0: the corresponding sync stays high.
- front=0: sync starts immediately after the active region.
REQ-030 A transfer in the same cycle as frame end goes to the shadow and is applied at the following frame end, not the current one.
REQ-031 Frame_start pulses exactly once per frame, including the first frame after a configuration change.

Reset
REQ-032 On Rst=1:
- state=IDLE; Have_cfg=0; Pend=0.
- Cfg_ready=1; Cfg_err=0.
- PixelX=0; PixelY=0; Hsync=1; Vsync=1; Display_en=0; Frame_start=0; Running=0.
REQ-033 Rst has priority over all inputs, including a same-cycle transfer, and aborts a frame mid-operation. Active and shadow contents are discarded.

Verification
REQ-034 Basic mode. Stimulus: H total/active/front/sync = 10/6/1/2, V = 5/3/1/1, Enable=1. Required response:
- frame period 50 cycles;
- Hsync low at X=7,8;
- Vsync low for Y=4;
- Display_en high for 18 cycles per frame;
- Frame_start every 50 cycles.
REQ-035 Mid-frame reconfiguration. Stimulus: offer H total 12 during RUN. Required response:
- Cfg_ready drops;
- the current frame keeps a 10-cycle line;
- from the next (0,0) the line is 12 cycles;
- Cfg_ready returns high.
REQ-036 Invalid configuration. Stimulus: H active 8, front 2, sync 2, total 10. Required response: Cfg_err pulses 1 cycle and timing is unchanged.
REQ-037 Stop. Stimulus: deassert Enable at X=3, Y=1. Required response: the frame runs to (9,4), then Running=0 and Hsync=Vsync=1.
REQ-038 Reset mid-frame. Stimulus: Rst at X=5, Y=2. Required response: next cycle all outputs at reset values and Cfg_ready=1.
REQ-039 Boundary transfer. Stimulus: transfer on the frame-end cycle. Required response: the new mode is applied one frame later (REQ-030).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: programmable raster generator with a validated
// configuration handshake and a one-entry shadow set that is swapped in
// only on frame boundaries, so a running frame is never torn.
module vga_timing_ctrl #(
   parameter int PULSE_WIDTH   = 8,
   parameter int REZ_MAX_WIDTH = 12
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Enable,
   input  logic                     Cfg_valid,
   output logic                     Cfg_ready,
   input  logic [REZ_MAX_WIDTH-1:0] Cfg_h_total,
   input  logic [REZ_MAX_WIDTH-1:0] Cfg_h_active,
   input  logic [REZ_MAX_WIDTH-1:0] Cfg_v_total,
   input  logic [REZ_MAX_WIDTH-1:0] Cfg_v_active,
   input  logic [PULSE_WIDTH-1:0]   Cfg_h_front,
   input  logic [PULSE_WIDTH-1:0]   Cfg_h_sync,
   input  logic [PULSE_WIDTH-1:0]   Cfg_v_front,
   input  logic [PULSE_WIDTH-1:0]   Cfg_v_sync,
   output logic                     Cfg_err,
   output logic                     Hsync,
   output logic                     Vsync,
   output logic                     Display_en,
   output logic [REZ_MAX_WIDTH-1:0] PixelX,
   output logic [REZ_MAX_WIDTH-1:0] PixelY,
   output logic                     Frame_start,
   output logic                     Running
);

   localparam int PW = PULSE_WIDTH;
   localparam int RW = REZ_MAX_WIDTH;

   typedef struct packed {
      logic [RW-1:0] ht;
      logic [RW-1:0] ha;
      logic [RW-1:0] vt;
      logic [RW-1:0] va;
      logic [PW-1:0] hf;
      logic [PW-1:0] hs;
      logic [PW-1:0] vf;
      logic [PW-1:0] vs;
   } cfg_t;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // One axis is usable when it has a visible region and active+front+sync
   // fits inside the total, with the sum carried at one extra bit.
   function automatic logic axis_ok(input logic [RW-1:0] total,
                                    input logic [RW-1:0] active,
                                    input logic [PW-1:0] front,
                                    input logic [PW-1:0] sync);
      logic [RW:0] sum;
      sum = (RW+1)'(active) + (RW+1)'(front) + (RW+1)'(sync);
      return (active != '0) && (sum <= (RW+1)'(total)) && (total >= RW'(2));
   endfunction

   // Sync window [active+front, active+front+sync); empty when sync is 0.
   function automatic logic in_sync(input logic [RW-1:0] pos,
                                    input logic [RW-1:0] active,
                                    input logic [PW-1:0] front,
                                    input logic [PW-1:0] sync);
      logic [RW+1:0] start;
      logic [RW+1:0] stop;
      start = (RW+2)'(active) + (RW+2)'(front);
      stop  = start + (RW+2)'(sync);
      return ((RW+2)'(pos) >= start) && ((RW+2)'(pos) < stop);
   endfunction

   state_t        state_q, state_d;
   cfg_t          act_q, act_d;
   cfg_t          shd_q, shd_d;
   cfg_t          cfg_in;
   logic          pend_q, pend_d;
   logic          have_q, have_d;
   logic          err_q, err_d;
   logic [RW-1:0] x_q, x_d;
   logic [RW-1:0] y_q, y_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic          fs_q, fs_d;
   logic          run_q, run_d;
   logic          xfer;
   logic          cfg_good;
   logic          h_last;
   logic          v_last;

   assign cfg_in = '{ht: Cfg_h_total, ha: Cfg_h_active, vt: Cfg_v_total,
                     va: Cfg_v_active, hf: Cfg_h_front, hs: Cfg_h_sync,
                     vf: Cfg_v_front, vs: Cfg_v_sync};

   assign xfer     = Cfg_valid && !pend_q;
   assign cfg_good = axis_ok(cfg_in.ht, cfg_in.ha, cfg_in.hf, cfg_in.hs) &&
                     axis_ok(cfg_in.vt, cfg_in.va, cfg_in.vf, cfg_in.vs);
   assign h_last   = (x_q == act_q.ht - RW'(1));
   assign v_last   = (y_q == act_q.vt - RW'(1));

   // Next state: handshake, shadow swap at frame end, raster counters.
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      have_d  = have_q;
      err_d   = 1'b0;
      x_d     = x_q;
      y_d     = y_q;

      case (state_q)
         ST_IDLE: begin
            x_d = '0;
            y_d = '0;
            if (have_q && Enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (h_last && v_last) begin
               x_d = '0;
               y_d = '0;
               if (pend_q) begin
                  act_d  = shd_q;
                  pend_d = 1'b0;
               end
               if (!Enable) begin
                  state_d = ST_IDLE;
               end
            end else if (h_last) begin
               x_d = '0;
               y_d = y_q + RW'(1);
            end else begin
               x_d = x_q + RW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A transfer only happens with Pend clear, so it never collides with
      // the frame-end swap above; on a frame-end cycle it lands in the shadow.
      if (xfer) begin
         if (!cfg_good) begin
            err_d = 1'b1;
         end else if (state_q == ST_IDLE) begin
            act_d  = cfg_in;
            have_d = 1'b1;
         end else begin
            shd_d  = cfg_in;
            pend_d = 1'b1;
         end
      end
   end

   // Output decode from the next position and next timing set, so the
   // registered outputs line up with the registered coordinates.
   always_comb begin
      run_d = (state_d == ST_RUN);
      de_d  = run_d && (x_d < act_d.ha) && (y_d < act_d.va);
      hs_d  = !(run_d && in_sync(x_d, act_d.ha, act_d.hf, act_d.hs));
      vs_d  = !(run_d && in_sync(y_d, act_d.va, act_d.vf, act_d.vs));
      fs_d  = run_d && (x_d == '0) && (y_d == '0);
   end

   // Control and output registers; reset discards any held configuration.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         have_q  <= 1'b0;
         err_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         have_q  <= have_d;
         err_q   <= err_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         run_q   <= run_d;
      end
   end

   // Timing sets carry no reset; Have_cfg/Pend decide whether they are used.
   always_ff @(posedge Clk) begin
      act_q <= act_d;
      shd_q <= shd_d;
   end

   assign Cfg_ready   = !pend_q;
   assign Cfg_err     = err_q;
   assign Hsync       = hs_q;
   assign Vsync       = vs_q;
   assign Display_en  = de_q;
   assign PixelX      = x_q;
   assign PixelY      = y_q;
   assign Frame_start = fs_q;
   assign Running     = run_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: reference model tracks the position as a single
// cycle-in-frame count and derives X/Y and the decodes arithmetically.
module tb_vga_timing_ctrl;

   localparam int PW = 8;
   localparam int RW = 12;
   localparam int VW = 2*RW + 7;
   localparam logic [VW-1:0] RST_VEC = {7'b0100011, {(2*RW){1'b0}}};

   typedef struct {
      int ht, ha, hf, hs, vt, va, vf, vs;
   } cfg_s;

   logic Clk = 1'b0;
   logic Rst, Enable, Cfg_valid;
   logic Cfg_ready, Cfg_err, Hsync, Vsync, Display_en, Frame_start, Running;
   logic [RW-1:0] PixelX, PixelY;
   logic [RW-1:0] Cfg_h_total, Cfg_h_active, Cfg_v_total, Cfg_v_active;
   logic [PW-1:0] Cfg_h_front, Cfg_h_sync, Cfg_v_front, Cfg_v_sync;

   cfg_s drv, m_act, m_shd;
   bit   m_run, m_pend, m_have, m_err;
   int   m_t;
   logic [VW-1:0] obs_vec, exp_vec;
   int   tests = 0;
   int   fails = 0;

   assign Cfg_h_total  = RW'(drv.ht);
   assign Cfg_h_active = RW'(drv.ha);
   assign Cfg_h_front  = PW'(drv.hf);
   assign Cfg_h_sync   = PW'(drv.hs);
   assign Cfg_v_total  = RW'(drv.vt);
   assign Cfg_v_active = RW'(drv.va);
   assign Cfg_v_front  = PW'(drv.vf);
   assign Cfg_v_sync   = PW'(drv.vs);

   always #5 Clk = ~Clk;

   vga_timing_ctrl #(.PULSE_WIDTH(PW), .REZ_MAX_WIDTH(RW)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Cfg_valid(Cfg_valid),
      .Cfg_ready(Cfg_ready), .Cfg_h_total(Cfg_h_total), .Cfg_h_active(Cfg_h_active),
      .Cfg_v_total(Cfg_v_total), .Cfg_v_active(Cfg_v_active),
      .Cfg_h_front(Cfg_h_front), .Cfg_h_sync(Cfg_h_sync),
      .Cfg_v_front(Cfg_v_front), .Cfg_v_sync(Cfg_v_sync), .Cfg_err(Cfg_err),
      .Hsync(Hsync), .Vsync(Vsync), .Display_en(Display_en), .PixelX(PixelX),
      .PixelY(PixelY), .Frame_start(Frame_start), .Running(Running));

   function automatic bit cfg_ok(input cfg_s c);
      int mask = (1 << (RW+1)) - 1;
      return (c.ha != 0) && (((c.ha + c.hf + c.hs) & mask) <= c.ht) && (c.ht >= 2) &&
             (c.va != 0) && (((c.va + c.vf + c.vs) & mask) <= c.vt) && (c.vt >= 2);
   endfunction

   function automatic logic [VW-1:0] model_view();
      int x, y;
      bit de, hsn, vsn, fs;
      x   = m_run ? m_t % m_act.ht : 0;
      y   = m_run ? m_t / m_act.ht : 0;
      de  = m_run && x < m_act.ha && y < m_act.va;
      hsn = !(m_run && x >= m_act.ha + m_act.hf && x < m_act.ha + m_act.hf + m_act.hs);
      vsn = !(m_run && y >= m_act.va + m_act.vf && y < m_act.va + m_act.vf + m_act.vs);
      fs  = m_run && m_t == 0;
      return {m_run, !m_pend, m_err, fs, de, hsn, vsn, x[RW-1:0], y[RW-1:0]};
   endfunction

   function automatic cfg_s mk(int ht, ha, hf, hs, vt, va, vf, vs);
      cfg_s c;
      c.ht = ht; c.ha = ha; c.hf = hf; c.hs = hs;
      c.vt = vt; c.va = va; c.vf = vf; c.vs = vs;
      return c;
   endfunction

   function automatic cfg_s rand_cfg();
      cfg_s c;
      c.ht = $urandom_range(16, 2); c.ha = $urandom_range(c.ht, 1);
      c.hf = $urandom_range(4, 0);  c.hs = $urandom_range(4, 0);
      c.vt = $urandom_range(8, 2);  c.va = $urandom_range(c.vt, 1);
      c.vf = $urandom_range(3, 0);  c.vs = $urandom_range(3, 0);
      return c;
   endfunction

   // One clock: model the edge from the inputs present before it, then sample.
   task automatic tick();
      bit r, en, v, xfer, ok, fe, old_run, old_pend, old_have;
      cfg_s c, old_shd;
      r = Rst; en = Enable; v = Cfg_valid; c = drv;
      @(posedge Clk);
      #1;
      if (r) begin
         m_run = 0; m_pend = 0; m_have = 0; m_err = 0; m_t = 0;
      end else begin
         old_run = m_run; old_pend = m_pend; old_have = m_have; old_shd = m_shd;
         xfer  = v && !old_pend;
         ok    = cfg_ok(c);
         fe    = old_run && (m_t == m_act.ht * m_act.vt - 1);
         m_err = xfer && !ok;
         if (!old_run) begin
            if (old_have && en) begin m_run = 1; m_t = 0; end
         end else if (fe) begin
            m_t = 0;
            if (old_pend) begin m_act = old_shd; m_pend = 0; end
            if (!en) m_run = 0;
         end else begin
            m_t++;
         end
         if (xfer && ok) begin
            if (!old_run) begin m_act = c; m_have = 1; end
            else begin m_shd = c; m_pend = 1; end
         end
      end
      exp_vec = model_view();
      obs_vec = {Running, Cfg_ready, Cfg_err, Frame_start, Display_en, Hsync, Vsync, PixelX, PixelY};
   endtask

   task automatic test_reset();
      Rst = 1; Enable = 0; Cfg_valid = 0; drv = mk(10, 6, 1, 2, 5, 3, 1, 1);
      tick(); tick();
      tests++; if (obs_vec !== RST_VEC) begin fails++; $display("FAIL reset_state got=%h exp=%h", obs_vec, RST_VEC); end
      tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL reset_model got=%h exp=%h", obs_vec, exp_vec); end
      Rst = 0;
      tick();
      tests++; if (obs_vec !== RST_VEC) begin fails++; $display("FAIL reset_idle got=%h exp=%h", obs_vec, RST_VEC); end
   endtask

   task automatic test_basic();
      int last_fs, nfs, de_acc, hs_acc, vs_acc;
      int hmask, vmask;
      nfs = 0; de_acc = 0; hs_acc = 0; vs_acc = 0; last_fs = 0; hmask = 0; vmask = 0;
      drv = mk(10, 6, 1, 2, 5, 3, 1, 1); Cfg_valid = 1;
      tick();
      Cfg_valid = 0; Enable = 1;
      for (int i = 0; i < 150; i++) begin
         tick();
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
         if (Frame_start) begin
            if (nfs > 0) begin
               tests++; if (i - last_fs != 50) begin fails++; $display("FAIL basic_period got=%0d exp=50", i - last_fs); end
               tests++; if (de_acc != 18) begin fails++; $display("FAIL basic_de_count got=%0d exp=18", de_acc); end
               tests++; if (hs_acc != 10) begin fails++; $display("FAIL basic_hs_count got=%0d exp=10", hs_acc); end
               tests++; if (vs_acc != 10) begin fails++; $display("FAIL basic_vs_count got=%0d exp=10", vs_acc); end
            end
            nfs++; last_fs = i; de_acc = 0; hs_acc = 0; vs_acc = 0;
         end
         if (Display_en) de_acc++;
         if (!Hsync) begin hs_acc++; hmask |= 1 << PixelX; end
         if (!Vsync) begin vs_acc++; vmask |= 1 << PixelY; end
      end
      tests++; if (nfs != 3) begin fails++; $display("FAIL basic_frames got=%0d exp=3", nfs); end
      tests++; if (hmask != 'h180) begin fails++; $display("FAIL basic_hsync_x got=%h exp=180", hmask); end
      tests++; if (vmask != 'h10) begin fails++; $display("FAIL basic_vsync_y got=%h exp=10", vmask); end
   endtask

   task automatic test_midframe_reconfig();
      int n, maxx;
      n = 0;
      while (!(m_run && m_t == 12) && n < 200) begin
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL mid_wait got=%h exp=%h", obs_vec, exp_vec); end
      end
      drv = mk(12, 6, 1, 2, 5, 3, 1, 1); Cfg_valid = 1;
      tick();
      Cfg_valid = 0;
      tests++; if (Cfg_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_drop got=%b exp=0", Cfg_ready); end
      maxx = 0; n = 0;
      while (Frame_start !== 1'b1 && n < 100) begin
         if (PixelX > maxx) maxx = PixelX;
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL mid_old got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (maxx != 9) begin fails++; $display("FAIL mid_old_line got=%0d exp=9", maxx); end
      tests++; if (Cfg_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_back got=%b exp=1", Cfg_ready); end
      maxx = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (PixelX > maxx) maxx = PixelX;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL mid_new got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (maxx != 11) begin fails++; $display("FAIL mid_new_line got=%0d exp=11", maxx); end
   endtask

   task automatic test_invalid();
      drv = mk(10, 8, 2, 2, 5, 3, 1, 1); Cfg_valid = 1;
      tick();
      Cfg_valid = 0;
      tests++; if (Cfg_err !== 1'b1) begin fails++; $display("FAIL invalid_err got=%b exp=1", Cfg_err); end
      tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL invalid_model got=%h exp=%h", obs_vec, exp_vec); end
      tick();
      tests++; if (Cfg_err !== 1'b0) begin fails++; $display("FAIL invalid_err_len got=%b exp=0", Cfg_err); end
      for (int i = 0; i < 80; i++) begin
         tick();
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL invalid_timing got=%h exp=%h", obs_vec, exp_vec); end
      end
   endtask

   task automatic test_boundary();
      int n;
      n = 0;
      while (!(m_run && m_t == m_act.ht * m_act.vt - 1) && n < 200) begin
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL bnd_wait got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (!(PixelX == 11 && PixelY == 4)) begin fails++; $display("FAIL bnd_frame_end got=%0d,%0d exp=11,4", PixelX, PixelY); end
      drv = mk(8, 4, 1, 1, 4, 2, 1, 1); Cfg_valid = 1;
      tick();
      Cfg_valid = 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL bnd_old got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (PixelX !== RW'(11)) begin fails++; $display("FAIL bnd_old_mode got=%0d exp=11", PixelX); end
      n = 0;
      while (Frame_start !== 1'b1 && n < 100) begin
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL bnd_run got=%h exp=%h", obs_vec, exp_vec); end
      end
      for (int i = 0; i < 8; i++) tick();
      tests++; if (!(PixelX == 0 && PixelY == 1)) begin fails++; $display("FAIL bnd_new_mode got=%0d,%0d exp=0,1", PixelX, PixelY); end
   endtask

   task automatic test_stop();
      int n, px, py;
      drv = mk(10, 6, 1, 2, 5, 3, 1, 1); Cfg_valid = 1;
      tick();
      Cfg_valid = 0;
      n = 0;
      while (!(m_run && m_act.ht == 10 && m_t == 13) && n < 300) begin
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL stop_wait got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (!(PixelX == 3 && PixelY == 1)) begin fails++; $display("FAIL stop_pos got=%0d,%0d exp=3,1", PixelX, PixelY); end
      Enable = 0; n = 0; px = 0; py = 0;
      while (Running === 1'b1 && n < 100) begin
         px = PixelX; py = PixelY;
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL stop_run got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (!(px == 9 && py == 4)) begin fails++; $display("FAIL stop_last got=%0d,%0d exp=9,4", px, py); end
      tests++; if ({Running, Hsync, Vsync} !== 3'b011) begin fails++; $display("FAIL stop_idle got=%b exp=011", {Running, Hsync, Vsync}); end
      tick();
      tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL stop_hold got=%h exp=%h", obs_vec, exp_vec); end
   endtask

   task automatic test_reset_midframe();
      int n;
      Enable = 1; n = 0;
      while (!(m_run && m_t == 25) && n < 100) begin
         tick(); n++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL rstm_wait got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (!(PixelX == 5 && PixelY == 2)) begin fails++; $display("FAIL rstm_pos got=%0d,%0d exp=5,2", PixelX, PixelY); end
      Rst = 1; Cfg_valid = 1; drv = mk(10, 6, 1, 2, 5, 3, 1, 1);
      tick();
      Rst = 0; Cfg_valid = 0;
      tests++; if (obs_vec !== RST_VEC) begin fails++; $display("FAIL rstm_state got=%h exp=%h", obs_vec, RST_VEC); end
      for (int i = 0; i < 5; i++) tick();
      tests++; if (obs_vec !== RST_VEC) begin fails++; $display("FAIL rstm_discard got=%h exp=%h", obs_vec, RST_VEC); end
   endtask

   task automatic test_zero_width();
      int hmask, vlow;
      hmask = 0; vlow = 0;
      drv = mk(6, 3, 0, 2, 3, 2, 0, 0); Cfg_valid = 1;
      tick();
      Cfg_valid = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!Hsync) hmask |= 1 << PixelX;
         if (!Vsync) vlow++;
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL zero got=%h exp=%h", obs_vec, exp_vec); end
      end
      tests++; if (hmask != 'h18) begin fails++; $display("FAIL zero_front got=%h exp=18", hmask); end
      tests++; if (vlow != 0) begin fails++; $display("FAIL zero_sync got=%0d exp=0", vlow); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         Rst       = ($urandom_range(499, 0) == 0);
         Enable    = ($urandom_range(9, 0) != 0);
         Cfg_valid = ($urandom_range(19, 0) == 0);
         if (Cfg_valid) drv = rand_cfg();
         tick();
         tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
      end
      Rst = 0; Cfg_valid = 0; Enable = 0;
   endtask

   initial begin
      m_act = mk(2, 1, 0, 0, 2, 1, 0, 0); m_shd = m_act;
      m_run = 0; m_pend = 0; m_have = 0; m_err = 0; m_t = 0;
      test_reset();
      test_basic();
      test_midframe_reconfig();
      test_invalid();
      test_boundary();
      test_stop();
      test_reset_midframe();
      test_zero_width();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
